// File: rtl/rvm_shift_unit_pkg.sv
// Shared shift-unit constants: op encodings, FSM states and shift width.
// Also used by rvm_control when driving f_shf_op.
package rvm_shift_unit_pkg;

    localparam int RVM_SHAMT_W = 5;

    localparam logic [1:0] RVM_SHF_OP_PASS = 2'b00;
    localparam logic [1:0] RVM_SHF_OP_SLL  = 2'b01;
    localparam logic [1:0] RVM_SHF_OP_SRL  = 2'b10;
    localparam logic [1:0] RVM_SHF_OP_SRA  = 2'b11;

    typedef enum logic [1:0] {
        RVM_SHF_IDLE  = 2'd0,
        RVM_SHF_SHIFT = 2'd1,
        RVM_SHF_DONE  = 2'd2
    } rvm_shf_state_t;

endpackage

// File: rtl/rvm_shift_step.sv
// Combinational single-bit shift by op; SRA replicates the current MSB.
// Pass-through returns the operand unchanged.
module rvm_shift_step
    import rvm_shift_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] d,
    input  logic [1:0]      op,
    output logic [XLEN-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            RVM_SHF_OP_SLL: q = {d[XLEN-2:0], 1'b0};
            RVM_SHF_OP_SRL: q = {1'b0, d[XLEN-1:1]};
            RVM_SHF_OP_SRA: q = {d[XLEN-1], d[XLEN-1:1]};
            default:        q = d;
        endcase
    end

endmodule

// File: rtl/rvm_shift_unit.sv
// RV32I SLL/SRL/SRA unit: iterative 1 bit/cycle by default,
// single-cycle barrel shifter when RVM_SHIFT_BARREL_EN is defined.
module rvm_shift_unit
    import rvm_shift_unit_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SHAMT_W = RVM_SHAMT_W
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            f_shf_en,
    input  logic [XLEN-1:0] f_shf_lhs,
    input  logic [XLEN-1:0] f_shf_rhs,
    input  logic [1:0]      f_shf_op,
    output logic            f_shf_valid,
    output logic [XLEN-1:0] f_shf_result
);

    rvm_shf_state_t     state;
    rvm_shf_state_t     state_nxt;
    logic [SHAMT_W-1:0] amt;
    logic               accept;
    logic               unused_rhs;

    assign amt        = f_shf_rhs[SHAMT_W-1:0];
    assign accept     = (state == RVM_SHF_IDLE) && f_shf_en;
    assign unused_rhs = ^f_shf_rhs[XLEN-1:SHAMT_W];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= RVM_SHF_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        f_shf_valid = (state == RVM_SHF_DONE);
    end

`ifdef RVM_SHIFT_BARREL_EN

    // Stage i applies one more bit of shift while i < amt.
    logic [XLEN-1:0] chain [XLEN];

    assign chain[0] = f_shf_lhs;

    for (genvar i = 0; i < XLEN - 1; i++) begin : g_stage
        logic [XLEN-1:0] stepped;

        rvm_shift_step #(
            .XLEN (XLEN)
        ) u_step (
            .d  (chain[i]),
            .op (f_shf_op),
            .q  (stepped)
        );

        assign chain[i+1] = (SHAMT_W'(i) < amt) ? stepped : chain[i];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RVM_SHF_IDLE: if (f_shf_en) state_nxt = RVM_SHF_DONE;
            RVM_SHF_DONE: state_nxt = RVM_SHF_IDLE;
            default:      state_nxt = RVM_SHF_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)     f_shf_result <= '0;
        else if (accept) f_shf_result <= chain[XLEN-1];
    end

`else

    logic [SHAMT_W-1:0] count;
    logic [1:0]         op_q;
    logic [XLEN-1:0]    stepped;

    rvm_shift_step #(
        .XLEN (XLEN)
    ) u_step (
        .d  (f_shf_result),
        .op (op_q),
        .q  (stepped)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            RVM_SHF_IDLE: begin
                if (f_shf_en) begin
                    if (amt == '0 || f_shf_op == RVM_SHF_OP_PASS)
                        state_nxt = RVM_SHF_DONE;
                    else
                        state_nxt = RVM_SHF_SHIFT;
                end
            end
            RVM_SHF_SHIFT: begin
                if (count == SHAMT_W'(1)) state_nxt = RVM_SHF_DONE;
            end
            RVM_SHF_DONE: state_nxt = RVM_SHF_IDLE;
            default:      state_nxt = RVM_SHF_IDLE;
        endcase
    end

    // Operands are latched at acceptance; later input changes are ignored.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            f_shf_result <= '0;
            count        <= '0;
            op_q         <= RVM_SHF_OP_PASS;
        end else if (accept) begin
            f_shf_result <= f_shf_lhs;
            count        <= amt;
            op_q         <= f_shf_op;
        end else if (state == RVM_SHF_SHIFT) begin
            f_shf_result <= stepped;
            count        <= count - SHAMT_W'(1);
        end
    end

`endif

endmodule

// File: tb/tb_rvm_shift_unit.sv
// Self-checking bench for rvm_shift_unit: directed cases plus random ops
// against an arithmetic reference model.
module tb_rvm_shift_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [1:0]  op;
    logic        valid;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    rvm_shift_unit dut (
        .clk          (clk),
        .resetn       (resetn),
        .f_shf_en     (en),
        .f_shf_lhs    (lhs),
        .f_shf_rhs    (rhs),
        .f_shf_op     (op),
        .f_shf_valid  (valid),
        .f_shf_result (result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_shift(logic [31:0] l, logic [31:0] r,
                                              logic [1:0] o);
        int a;
        a = int'(r[4:0]);
        case (o)
            2'd1:    return l << a;
            2'd2:    return l >> a;
            2'd3:    return 32'($signed(l) >>> a);
            default: return l;
        endcase
    endfunction

    function automatic int ref_lat(logic [31:0] r, logic [1:0] o);
`ifdef RVM_SHIFT_BARREL_EN
        return 1;
`else
        if (o == 2'd0 || r[4:0] == 5'd0) return 1;
        return int'(r[4:0]) + 1;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    task automatic start(input logic [31:0] l, input logic [31:0] r,
                         input logic [1:0] o);
        @(negedge clk);
        en  = 1'b1;
        lhs = l;
        rhs = r;
        op  = o;
        @(posedge clk);
        #1;
    endtask

    // Edges counted from acceptance (inclusive) until valid is seen.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] l,
                          input logic [31:0] r, input logic [1:0] o);
        int lat;
        start(l, r, o);
        en  = 1'b0;
        lhs = $urandom;
        rhs = $urandom;
        op  = 2'($urandom);
        wait_done(lat);
        check({tag, "_res"}, result, ref_shift(l, r, o));
        check({tag, "_lat"}, 32'(lat), 32'(ref_lat(r, o)));
        @(posedge clk);
        #1;
        check({tag, "_after"}, 32'(valid), 32'd0);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [31:0] rl, rr;
        logic [1:0]  ro;

        resetn = 1'b0;
        en     = 1'b0;
        lhs    = '0;
        rhs    = '0;
        op     = '0;
        #12;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_result", result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("sll31", 32'h0000_0001, 32'd31, 2'd1);
        check("sll31_val", result, 32'h8000_0000);
        run_op("sra4", 32'h8000_0000, 32'h0000_0024, 2'd3);
        check("sra4_val", result, 32'hF800_0000);
        run_op("srl4", 32'h8000_0000, 32'h0000_0024, 2'd2);
        check("srl4_val", result, 32'h0800_0000);
        run_op("pass", 32'hDEAD_BEEF, 32'd5, 2'd0);
        check("pass_val", result, 32'hDEAD_BEEF);
        run_op("amt0", 32'hDEAD_BEEF, 32'hFFFF_FFE0, 2'd1);
        check("amt0_val", result, 32'hDEAD_BEEF);

        // Operand churn during the shift, request held into the next op.
        start(32'hFFFF_0000, 32'd8, 2'd2);
        lhs = 32'h0000_0003;
        rhs = 32'd1;
        op  = 2'd1;
        lat = 1;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            en = ~en;
        end
        en = 1'b1;
        check("b2b_res", result, 32'h00FF_FF00);
        check("b2b_lat", 32'(lat), 32'(ref_lat(32'd8, 2'd2)));
        @(posedge clk);
        #1;
        check("b2b_gap", 32'(valid), 32'd0);
        check("b2b_hold", result, 32'h00FF_FF00);
        @(posedge clk);
        #1;
        en = 1'b0;
        wait_done(lat);
        check("b2b2_res", result, 32'h0000_0006);
        check("b2b2_lat", 32'(lat), 32'(ref_lat(32'd1, 2'd1)));
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a long shift.
        start(32'h0000_0001, 32'd20, 2'd1);
        en = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_result", result, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid) pulses++;
        end
        check("mid_rst_nopulse", 32'(pulses), 32'd0);
        run_op("post_rst", 32'h1234_5678, 32'd3, 2'd1);

        for (int n = 0; n < 1000; n++) begin
            rl = $urandom;
            rr = $urandom;
            ro = 2'($urandom_range(0, 3));
            run_op("rand", rl, rr, ro);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
